// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - byte-stream program loader that fills instruction memory, then releases the core
//
// Purpose:
//   Accepts a framed byte stream and writes it into instruction memory at word
//   index 0,1,2,... while the core is held.
//   Frame: LEN_HI, LEN_LO (big-endian 16-bit word count N), then 4*N data
//   bytes. Each word is packed big-endian, so the first byte of a word lands in
//   imem_wdata[31:24]. The core is released once the last word has been written.
//
// Optional feature (macro CHECKSUM_EN):
//   When CHECKSUM_EN is defined, one checksum byte follows the data. It must
//   equal the XOR of every LEN and data byte. A match releases the core. A
//   mismatch raises load_err, and words already written stay in memory.
//   When CHECKSUM_EN is undefined, there is no checksum byte.
//
// Parameters:
//   ADDR_WIDTH    word-index width of imem_addr (capacity 2**ADDR_WIDTH words, max 16)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_data       stream byte
//   in_valid      in_data valid
//   in_ready      loader accepts a byte this cycle
//   imem_we       instruction-memory write strobe, one cycle per word
//   imem_addr     word index of the write
//   imem_wdata    packed instruction word
//   cpu_run       1 = core may fetch/execute, 0 = core held
//   load_err      sticky error flag, cleared only by reset
//   words_loaded  number of words written so far
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  load_err,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    // Capacity is held in 17 bits so that a 16-bit count can be compared
    // against 2**16 without overflow.
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    state_t                  state_q;
    logic                    in_ready_q;
    logic                    imem_we_q;
    logic [ADDR_WIDTH-1:0]   imem_addr_q;
    logic [31:0]             imem_wdata_q;
    logic                    cpu_run_q;
    logic                    load_err_q;
    logic [15:0]             words_loaded_q;

    logic [7:0]              len_hi_q;      // first length byte, held until LEN_LO arrives
    logic [15:0]             len_q;         // word count N of the current frame
    logic [15:0]             word_idx_q;    // index of the word being assembled
    logic [1:0]              byte_cnt_q;    // byte position inside the current word
    logic [23:0]             shift_q;       // first three bytes of the current word
`ifdef CHECKSUM_EN
    logic [7:0]              csum_q;        // running XOR of LEN and data bytes
`endif

    logic                    accept;
    logic [15:0]             len_word;
    logic                    len_too_big;
    logic                    last_word;
    logic [31:0]             word_d;

    assign accept      = in_valid && in_ready_q;
    assign len_word    = {len_hi_q, in_data};
    assign len_too_big = {1'b0, len_word} > CAPACITY;
    assign last_word   = (word_idx_q == len_q - 16'd1);
    assign word_d      = {shift_q, in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_LEN_HI;
            in_ready_q     <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= '0;
            cpu_run_q      <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= '0;
            len_hi_q       <= '0;
            len_q          <= '0;
            word_idx_q     <= '0;
            byte_cnt_q     <= '0;
            shift_q        <= '0;
`ifdef CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse.
            // Address and data keep their values until the next write.
            imem_we_q <= 1'b0;

            case (state_q)
                S_LEN_HI: begin
                    // in_ready leaves reset low and rises on the first clock after release.
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        len_hi_q <= in_data;
`ifdef CHECKSUM_EN
                        csum_q   <= in_data;
`endif
                        state_q  <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (accept) begin
                        len_q      <= len_word;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
`ifdef CHECKSUM_EN
                        csum_q     <= csum_q ^ in_data;
`endif
                        if (len_word == 16'd0) begin
                            // An empty image releases the core right away.
                            state_q    <= S_DONE;
                            in_ready_q <= 1'b0;
                            cpu_run_q  <= 1'b1;
                        end else if (len_too_big) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            load_err_q <= 1'b1;
                        end else begin
                            state_q    <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
`ifdef CHECKSUM_EN
                        csum_q     <= csum_q ^ in_data;
`endif
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            imem_we_q      <= 1'b1;
                            imem_addr_q    <= word_idx_q[ADDR_WIDTH-1:0];
                            imem_wdata_q   <= word_d;
                            word_idx_q     <= word_idx_q + 16'd1;
                            // The count updates together with the strobe.
                            words_loaded_q <= word_idx_q + 16'd1;
                            if (last_word) begin
`ifdef CHECKSUM_EN
                                state_q    <= S_CHK;
`else
                                // cpu_run follows one cycle later, from DONE.
                                state_q    <= S_DONE;
                                in_ready_q <= 1'b0;
`endif
                            end
                        end else begin
                            shift_q <= {shift_q[15:0], in_data};
                        end
                    end
                end

`ifdef CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q   <= S_DONE;
                            cpu_run_q <= 1'b1;
                        end else begin
                            state_q    <= S_ERR;
                            load_err_q <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE: begin
                    in_ready_q <= 1'b0;
                    cpu_run_q  <= 1'b1;
                end

                S_ERR: begin
                    in_ready_q <= 1'b0;
                    cpu_run_q  <= 1'b0;
                    load_err_q <= 1'b1;
                end

                default: begin
                    // Any unreachable encoding locks the loader out until reset.
                    state_q    <= S_ERR;
                    in_ready_q <= 1'b0;
                    load_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;

    localparam int AW = 8;
`ifdef CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_run;
    logic          load_err;
    logic [15:0]   words_loaded;

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] words[$];
    logic [7:0]  frame[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    bit          drv_done;
    int          acc_cyc;
    int          last_we_cyc;
    int          run_cyc;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Enter and leave at a negedge; in_ready is stable there.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (ok) acc_cyc = cyc;
    endtask

    task automatic drive_frame(input int gmin, input int gmax);
        bit ok;
        foreach (frame[i]) begin
            send_byte(frame[i], $urandom_range(gmax, gmin), ok);
            check("byte_accept", ok, 1);
        end
        drv_done = 1'b1;
    endtask

    task automatic monitor();
        int tail;
        bit prev_run;
        tail        = 0;
        prev_run    = cpu_run;
        run_cyc     = -1;
        last_we_cyc = -1;
        for (int t = 0; t < 20000 && tail < 6; t++) begin
            @(negedge clk);
            if (drv_done) tail++;
            if (imem_we) begin
                last_we_cyc = cyc;
                if (exp_addr.size() == 0) begin
                    check("we_unexpected", 1, 0);
                end else begin
                    check("we_addr", imem_addr, exp_addr.pop_front());
                    check("we_data", imem_wdata, exp_data.pop_front());
                end
            end
            if (cpu_run && !prev_run) run_cyc = cyc;
            prev_run = cpu_run;
        end
        if (tail < 6) check("monitor_timeout", 0, 1);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_outputs",
                 {in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_err, words_loaded}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1);
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Reference: the frame, expected writes and final status follow directly from N and the word list.
    task automatic run_frame(input int n, input int gmin, input int gmax, input bit chk_bad);
        logic [7:0] x;
        bit         ok;
        bit         data_ok;
        bit         exp_err;
        bit         exp_run;
        int         exp_wl;
        data_ok = (n >= 1) && (n <= (1 << AW));
        frame.delete();
        exp_addr.delete();
        exp_data.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        if (data_ok) begin
            for (int i = 0; i < n; i++) begin
                for (int b = 3; b >= 0; b--) frame.push_back(8'(words[i] >> (8 * b)));
                exp_addr.push_back(i);
                exp_data.push_back(words[i]);
            end
        end
        if (CHK_ON && data_ok) begin
            x = 8'h00;
            foreach (frame[i]) x ^= frame[i];
            if (chk_bad) x ^= 8'($urandom_range(255, 1));
            frame.push_back(x);
        end
        exp_err = (n > (1 << AW)) || (CHK_ON && data_ok && chk_bad);
        exp_run = !exp_err;
        exp_wl  = data_ok ? n : 0;

        drv_done = 1'b0;
        fork
            drive_frame(gmin, gmax);
            monitor();
        join

        check("pending_writes", exp_addr.size(), 0);
        check("words_loaded", words_loaded, exp_wl);
        check("load_err", load_err, exp_err);
        check("cpu_run", cpu_run, exp_run);
        check("in_ready_closed", in_ready, 0);
        if (data_ok && !CHK_ON) begin
            check("we_latency", last_we_cyc, acc_cyc);
            check("run_timing", run_cyc, acc_cyc + 1);
        end else if (exp_run) begin
            check("run_timing", run_cyc, acc_cyc);
        end else begin
            check("run_never", run_cyc, -1);
        end
        send_byte(8'($urandom), 0, ok);
        check("closed_no_accept", ok, 0);
        check("cpu_run_held", cpu_run, exp_run);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // Directed image: two words, back-to-back bytes.
        words = '{32'h20080005, 32'hAC080000};
        run_frame(2, 0, 0, 1'b0);

        // Empty image.
        do_reset();
        run_frame(0, 0, 0, 1'b0);

        // Oversized count (257 words > 256).
        do_reset();
        run_frame(257, 0, 0, 1'b0);

        // Same directed image, one byte every third cycle.
        do_reset();
        words = '{32'h20080005, 32'hAC080000};
        run_frame(2, 2, 2, 1'b0);

        // Reset after 5 data bytes: word 0 is written, then the load is abandoned.
        do_reset();
        frame    = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC};
        exp_addr = '{0};
        exp_data = '{32'h20080005};
        drv_done = 1'b0;
        fork
            drive_frame(0, 0);
            monitor();
        join
        check("mid_pending", exp_addr.size(), 0);
        check("mid_words", words_loaded, 1);
        check("mid_run", cpu_run, 0);
        do_reset();
        check("mid_words_cleared", words_loaded, 0);
        check("mid_run_cleared", cpu_run, 0);
        words = '{32'h20080005, 32'hAC080000};
        run_frame(2, 0, 1, 1'b0);

        // Randomised images with random gaps.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(12, 1);
            do_reset();
            fill_words(n);
            run_frame(n, 0, 2, 1'b0);
        end

        // Exactly full capacity.
        do_reset();
        fill_words(1 << AW);
        run_frame(1 << AW, 0, 0, 1'b0);

        // Corrupted checksum (only changes the outcome when the checksum is built in).
        do_reset();
        fill_words(3);
        run_frame(3, 0, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
